// File: rtl/sprite_motion_ctrl_if.sv
// Configuration bus between a host (master) and the sprite motion controller (slave).
//  cfg_we    write strobe, one cycle per write
//  cfg_sel   target register: 0 = x, 1 = y, 2 = vx, 3 = vy
//  cfg_data  write data; vx/vy take the low bits as a signed velocity
interface sprite_motion_ctrl_if #(
   parameter int unsigned CORDW = 12
);
   logic             cfg_we;
   logic [1:0]       cfg_sel;
   logic [CORDW-1:0] cfg_data;

   modport master (output cfg_we, cfg_sel, cfg_data);
   modport slave  (input  cfg_we, cfg_sel, cfg_data);
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion/animation controller.
// On an accepted vblank strobe it steps x, then y, then the animation counter,
// one state per cycle. It also raises a one-cycle start pulse at the first
// blanking pixel of the line above the sprite, and outputs the ROM base address
// of the current animation frame.
//  clk, rst          pixel clock, asynchronous active-high reset
//  en                enables motion, animation and start pulses
//  frame             vblank strobe
//  sx, sy            current raster position
//  cfg               configuration bus (slave)
//  sprx, spry        sprite position
//  spr_start         start pulse to the sprite engine
//  frame_base        ROM base address of the current animation frame
//  busy              per-frame update in progress
module sprite_motion_ctrl #(
   parameter int unsigned CORDW      = 12,
   parameter int unsigned SPDW       = 8,
   parameter int unsigned H_RES_FULL = 2200,
   parameter int unsigned V_RES_FULL = 1125,
   parameter int unsigned H_START    = 1920,
   parameter int unsigned SPR_PIXELS = 640,
   parameter int unsigned FRAMES     = 4,
   parameter int unsigned ANIM_DIV   = 8,
   parameter int unsigned ADDRW      = 12,
   parameter int unsigned X_INIT     = 0,
   parameter int unsigned Y_INIT     = 420,
   parameter int          VX_INIT    = -6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    frame,
   input  logic [CORDW-1:0]        sx,
   input  logic [CORDW-1:0]        sy,
   sprite_motion_ctrl_if.slave     cfg,
   output logic [CORDW-1:0]        sprx,
   output logic [CORDW-1:0]        spry,
   output logic                    spr_start,
   output logic [ADDRW-1:0]        frame_base,
   output logic                    busy
);
   localparam int unsigned CW2 = CORDW + 2;
   localparam int unsigned AW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int unsigned DW  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic signed [CW2-1:0] H_N = CW2'(H_RES_FULL);
   localparam logic signed [CW2-1:0] V_N = CW2'(V_RES_FULL);

   typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, UPD_ANIM} state_t;

   state_t                   state_q, state_d;
   logic [CORDW-1:0]         sprx_q, sprx_d, spry_q, spry_d;
   logic signed [SPDW-1:0]   vx_q, vx_d, vy_q, vy_d;
   logic [CORDW-1:0]         px_q, px_d, py_q, py_d;
   logic                     px_vld_q, px_vld_d, py_vld_q, py_vld_d;
   logic                     hold_vld_q, hold_vld_d, hold_vy_q, hold_vy_d;
   logic [CORDW-1:0]         hold_data_q, hold_data_d;
   logic [AW-1:0]            anim_q, anim_d;
   logic [DW-1:0]            div_q, div_d;
   logic [ADDRW-1:0]         frame_base_q, frame_base_d;
   logic                     spr_start_q, spr_start_d;
   logic                     busy_q, busy_d;
   logic                     wr_x, wr_y, wr_vx, wr_vy, y_defer;
   logic [CORDW-1:0]         sy_tgt;

   // Position step with a single wrap correction; requires |v| < n.
   function automatic logic [CORDW-1:0] wrap(input logic [CORDW-1:0] p,
                                             input logic signed [SPDW-1:0] v,
                                             input logic signed [CW2-1:0] n);
      logic signed [CW2-1:0] s;
      s = $signed({2'b00, p}) + CW2'(v);
      if (s[CW2-1])   s = s + n;
      else if (s >= n) s = s - n;
      return s[CORDW-1:0];
   endfunction

   assign wr_x  = cfg.cfg_we && (cfg.cfg_sel == 2'd0);
   assign wr_y  = cfg.cfg_we && (cfg.cfg_sel == 2'd1);
   assign wr_vx = cfg.cfg_we && (cfg.cfg_sel == 2'd2);
   assign wr_vy = cfg.cfg_we && (cfg.cfg_sel == 2'd3);
   // y-side writes landing in UPD_X must not reach the UPD_Y that follows.
   assign y_defer = (state_q == UPD_X) && (wr_y || wr_vy);
   assign sy_tgt  = (spry_q == '0) ? CORDW'(V_RES_FULL - 1) : spry_q - CORDW'(1);

   // Next-state, datapath and output logic.
   always_comb begin
      state_d      = state_q;
      sprx_d       = sprx_q;
      spry_d       = spry_q;
      vx_d         = vx_q;
      vy_d         = vy_q;
      px_d         = px_q;
      py_d         = py_q;
      px_vld_d     = px_vld_q;
      py_vld_d     = py_vld_q;
      hold_vld_d   = hold_vld_q;
      hold_vy_d    = hold_vy_q;
      hold_data_d  = hold_data_q;
      anim_d       = anim_q;
      div_d        = div_q;

      unique case (state_q)
         IDLE: if (frame && en) state_d = UPD_X;
         UPD_X: begin
            state_d = UPD_Y;
            if (px_vld_q) begin
               sprx_d   = px_q;
               px_vld_d = 1'b0;
            end else begin
               sprx_d = wrap(sprx_q, vx_q, H_N);
            end
         end
         UPD_Y: begin
            state_d = UPD_ANIM;
            if (py_vld_q) begin
               spry_d   = py_q;
               py_vld_d = 1'b0;
            end else begin
               spry_d = wrap(spry_q, vy_q, V_N);
            end
            // Release the write parked during UPD_X, after this update used the old values.
            if (hold_vld_q) begin
               hold_vld_d = 1'b0;
               if (hold_vy_q) begin
                  vy_d = hold_data_q[SPDW-1:0];
               end else begin
                  py_d     = hold_data_q;
                  py_vld_d = 1'b1;
               end
            end
         end
         UPD_ANIM: begin
            state_d = IDLE;
            if (div_q == DW'(ANIM_DIV - 1)) begin
               div_d  = '0;
               anim_d = (anim_q == AW'(FRAMES - 1)) ? '0 : anim_q + AW'(1);
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Config writes come after the update so the newest write wins.
      if (wr_x) begin
         px_d     = cfg.cfg_data;
         px_vld_d = 1'b1;
      end
      if (wr_vx) vx_d = cfg.cfg_data[SPDW-1:0];
      if (y_defer) begin
         hold_vld_d  = 1'b1;
         hold_vy_d   = wr_vy;
         hold_data_d = cfg.cfg_data;
      end else begin
         if (wr_y) begin
            py_d     = cfg.cfg_data;
            py_vld_d = 1'b1;
         end
         if (wr_vy) vy_d = cfg.cfg_data[SPDW-1:0];
      end

      frame_base_d = ADDRW'(32'(anim_d) * SPR_PIXELS);
      busy_d       = (state_d != IDLE);
      spr_start_d  = en && (sx == CORDW'(H_START - 1)) && (sy == sy_tgt);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sprx_q       <= CORDW'(X_INIT);
         spry_q       <= CORDW'(Y_INIT);
         vx_q         <= SPDW'(VX_INIT);
         vy_q         <= '0;
         px_q         <= '0;
         py_q         <= '0;
         px_vld_q     <= 1'b0;
         py_vld_q     <= 1'b0;
         hold_vld_q   <= 1'b0;
         hold_vy_q    <= 1'b0;
         hold_data_q  <= '0;
         anim_q       <= '0;
         div_q        <= '0;
         frame_base_q <= '0;
         spr_start_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sprx_q       <= sprx_d;
         spry_q       <= spry_d;
         vx_q         <= vx_d;
         vy_q         <= vy_d;
         px_q         <= px_d;
         py_q         <= py_d;
         px_vld_q     <= px_vld_d;
         py_vld_q     <= py_vld_d;
         hold_vld_q   <= hold_vld_d;
         hold_vy_q    <= hold_vy_d;
         hold_data_q  <= hold_data_d;
         anim_q       <= anim_d;
         div_q        <= div_d;
         frame_base_q <= frame_base_d;
         spr_start_q  <= spr_start_d;
         busy_q       <= busy_d;
      end
   end

   assign sprx       = sprx_q;
   assign spry       = spry_q;
   assign spr_start  = spr_start_q;
   assign frame_base = frame_base_q;
   assign busy       = busy_q;
endmodule
